// File: rtl/cache_ace_master.sv
// ACE master for the cache controller: turns read/write/invalidate requests into single-beat
// ReadShared / WriteBack / CleanUnique transactions, one outstanding, with a per-state timeout.
module cache_ace_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic                  ace_error,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic                  rd_shared,
  output logic                  rd_pass_dirty,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arsnoop,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [LINE_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsnoop,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [LINE_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  rack,
  output logic                  wack
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;
  typedef enum logic [1:0] {K_READ, K_INVAL, K_WRITE} kind_t;

  localparam logic [15:0] L_CNT_LAST = 16'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_next;
  kind_t                 r_kind;
  kind_t                 w_kind;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wb_data;
  logic [LINE_WIDTH-1:0] r_rd_data;
  logic                  r_rd_shared;
  logic                  r_rd_pass_dirty;
  logic [15:0]           r_cnt;
  logic                  r_err;
  logic                  r_tmo;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_inv_pend;
  logic [ADDR_WIDTH-1:0] r_inv_addr;

  logic                  w_inv_any;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic                  w_expire;
  logic                  w_timeout;
  logic                  w_aw_hs;
  logic                  w_w_hs;

  // An invalidate pulse that loses arbitration to a writeback is parked and served next.
  assign w_inv_any  = invalid_req | r_inv_pend;
  assign w_accept   = (r_state == S_IDLE) && (write_req || w_inv_any || read_req);
  assign w_kind     = write_req ? K_WRITE : (w_inv_any ? K_INVAL : K_READ);
  assign w_acc_addr = (w_kind == K_INVAL && !invalid_req) ? r_inv_addr : req_addr;
  assign w_expire   = (r_cnt == L_CNT_LAST);
  assign w_aw_hs    = (r_state == S_AW_W) && !r_aw_done && awready;
  assign w_w_hs     = (r_state == S_AW_W) && !r_w_done && wready;

  assign araddr        = r_addr;
  assign awaddr        = r_addr;
  assign wdata         = r_wb_data;
  assign rd_data       = r_rd_data;
  assign rd_shared     = r_rd_shared;
  assign rd_pass_dirty = r_rd_pass_dirty;

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    arvalid      = 1'b0;
    arsnoop      = '0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    awsnoop      = '0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    ace_ready    = 1'b0;
    ace_error    = 1'b0;
    rack         = 1'b0;
    wack         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (w_kind == K_WRITE) ? S_AW_W : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        arsnoop = (r_kind == K_INVAL) ? 4'b1011 : 4'b0001;
        if (arready) begin
          w_state_next = S_R;
        end else if (w_expire) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          w_state_next = S_DONE;
        end else if (w_expire) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_AW_W: begin
        awvalid = !r_aw_done;
        awsnoop = r_aw_done ? 3'b000 : 3'b011;
        wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_next = S_B;
        end else if (w_expire) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          w_state_next = S_DONE;
        end else if (w_expire) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_DONE: begin
        ace_ready    = 1'b1;
        ace_error    = r_err;
        rack         = !r_tmo && (r_kind != K_WRITE);
        wack         = !r_tmo && (r_kind == K_WRITE);
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_kind          <= K_READ;
      r_addr          <= '0;
      r_wb_data       <= '0;
      r_rd_data       <= '0;
      r_rd_shared     <= 1'b0;
      r_rd_pass_dirty <= 1'b0;
      r_cnt           <= '0;
      r_err           <= 1'b0;
      r_tmo           <= 1'b0;
      r_aw_done       <= 1'b0;
      r_w_done        <= 1'b0;
      r_inv_pend      <= 1'b0;
      r_inv_addr      <= '0;
    end else begin
      r_state <= w_state_next;
      // Counter restarts on every state entry and only runs in the channel-wait states.
      if (w_state_next != r_state || r_state == S_IDLE || r_state == S_DONE) r_cnt <= '0;
      else                                                                   r_cnt <= r_cnt + 16'd1;

      if (w_accept) begin
        r_kind    <= w_kind;
        r_addr    <= w_acc_addr;
        r_err     <= 1'b0;
        r_tmo     <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (w_kind == K_WRITE) r_wb_data <= wb_data;
        if (w_kind == K_WRITE && invalid_req) begin
          r_inv_pend <= 1'b1;
          r_inv_addr <= req_addr;
        end else if (w_kind == K_INVAL) begin
          r_inv_pend <= 1'b0;
        end
      end

      if (r_state == S_R && rvalid) begin
        if (rresp[1:0] != 2'b00) begin
          r_err <= 1'b1;
        end else if (r_kind == K_READ) begin
          r_rd_data       <= rdata;
          r_rd_shared     <= rresp[3];
          r_rd_pass_dirty <= rresp[2];
        end
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (r_state == S_B && bvalid && bresp != 2'b00) r_err <= 1'b1;
      if (w_timeout) begin
        r_err <= 1'b1;
        r_tmo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ace_master.sv
// Scoreboard bench for cache_ace_master: directed requests push expected completions,
// a monitor pops and checks them as the DUT reports handshakes and ace_ready.
module tb_cache_ace_master;
  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_req, write_req, invalid_req;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] wb_data;
  logic          ace_ready, ace_error, rd_shared, rd_pass_dirty;
  logic [LW-1:0] rd_data;
  logic [AW-1:0] araddr, awaddr;
  logic [3:0]    arsnoop;
  logic          arvalid, arready;
  logic [LW-1:0] rdata, wdata;
  logic [3:0]    rresp;
  logic          rvalid, rready;
  logic [2:0]    awsnoop;
  logic          awvalid, awready, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready, rack, wack;

  cache_ace_master #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req),
    .invalid_req(invalid_req), .req_addr(req_addr), .wb_data(wb_data),
    .ace_ready(ace_ready), .ace_error(ace_error), .rd_data(rd_data),
    .rd_shared(rd_shared), .rd_pass_dirty(rd_pass_dirty),
    .araddr(araddr), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .rack(rack), .wack(wack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic        err, rack, wack;
    logic [LW-1:0] rd;
    logic        sh, pd;
  } exp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    snoop;
  } ar_t;

  exp_t          done_q[$];
  ar_t           ar_q[$];
  logic [AW-1:0] aw_q[$];
  logic [LW-1:0] w_q[$];

  // Interconnect model knobs (-1 = never respond)
  int            ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [LW-1:0] rsp_rdata = '0;
  logic [3:0]    rsp_rresp = '0;
  logic [1:0]    rsp_bresp = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_done(input int c, input logic err, input logic rk, input logic wk,
                           input logic [LW-1:0] rd, input logic sh, input logic pd);
    exp_t e;
    e.cyc = c; e.err = err; e.rack = rk; e.wack = wk; e.rd = rd; e.sh = sh; e.pd = pd;
    done_q.push_back(e);
  endtask

  task automatic push_ar(input logic [AW-1:0] a, input logic [3:0] s);
    ar_t t;
    t.addr = a; t.snoop = s;
    ar_q.push_back(t);
  endtask

  task automatic wait_ready(input int bound);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ace_ready && k < bound);
    if (!ace_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: ace_ready not seen within %0d cycles", bound);
    end
  endtask

  // Responder: drives ready/valid on the negedge according to the wait knobs.
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      if (arvalid) begin arready = (ar_cnt == ar_wait); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      rdata = rsp_rdata;
      rresp = rsp_rresp;
      if (rready) begin rvalid = (r_cnt == r_wait); r_cnt++; end
      else begin rvalid = 1'b0; r_cnt = 0; end
      if (awvalid) begin awready = (aw_cnt == aw_wait); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt == w_wait); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      bresp = rsp_bresp;
      if (bready) begin bvalid = (b_cnt == b_wait); b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
    end
  end

  // Monitor: checks completions and channel handshakes against the queues.
  initial begin
    logic          p_ar_hs, p_aw_hs, p_w_hs, p_arvalid;
    logic [AW-1:0] p_araddr;
    logic [3:0]    p_arsnoop;
    exp_t          e;
    ar_t           a;
    int            n_txn;
    p_ar_hs = 1'b0; p_aw_hs = 1'b0; p_w_hs = 1'b0; p_arvalid = 1'b0;
    p_araddr = '0; p_arsnoop = '0; n_txn = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        p_ar_hs = 1'b0; p_aw_hs = 1'b0; p_w_hs = 1'b0; p_arvalid = 1'b0;
        continue;
      end
      if (ace_ready) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: ace_ready at cycle %0d with nothing expected", cyc);
        end else begin
          e = done_q.pop_front();
          n_txn++;
          $display("txn %0d cyc %0d err=%b rack=%b wack=%b shared=%b pd=%b rd_data=%h",
                   n_txn, cyc, ace_error, rack, wack, rd_shared, rd_pass_dirty, rd_data);
          chk("ready_cycle", 128'(cyc), 128'(e.cyc));
          chk("ace_error", 128'(ace_error), 128'(e.err));
          chk("rack", 128'(rack), 128'(e.rack));
          chk("wack", 128'(wack), 128'(e.wack));
          chk("rd_data", rd_data, e.rd);
          chk("rd_flags", 128'({rd_shared, rd_pass_dirty}), 128'({e.sh, e.pd}));
          chk("done_valids_low", 128'({arvalid, rready, awvalid, wvalid, bready}), '0);
        end
      end else if (rack || wack) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_ack: rack=%b wack=%b without ace_ready", rack, wack);
      end
      if (p_ar_hs) chk("ar_drop", 128'(arvalid), '0);
      if (p_aw_hs) chk("aw_drop", 128'(awvalid), '0);
      if (p_w_hs)  chk("w_drop", 128'(wvalid), '0);
      if (p_arvalid && !p_ar_hs && arvalid)
        chk("ar_stable", 128'({araddr, arsnoop}), 128'({p_araddr, p_arsnoop}));
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ar: addr %h snoop %b", araddr, arsnoop);
        end else begin
          a = ar_q.pop_front();
          chk("araddr", 128'(araddr), 128'(a.addr));
          chk("arsnoop", 128'(arsnoop), 128'(a.snoop));
        end
      end
      if (awvalid && awready) begin
        if (aw_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_aw: addr %h", awaddr);
        end else begin
          chk("awaddr", 128'(awaddr), 128'(aw_q.pop_front()));
          chk("awsnoop", 128'(awsnoop), 128'(3'b011));
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_w: data %h", wdata);
        end else begin
          chk("wdata", wdata, w_q.pop_front());
        end
      end
      p_ar_hs   = arvalid && arready;
      p_aw_hs   = awvalid && awready;
      p_w_hs    = wvalid && wready;
      p_arvalid = arvalid;
      p_araddr  = araddr;
      p_arsnoop = arsnoop;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            c;
    logic [LW-1:0] fill_a5, fill_12, fill_55;
    fill_a5 = {16{8'hA5}};
    fill_12 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    fill_55 = {16{8'h55}};
    reset = 1'b0; read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    req_addr = '0; wb_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_valids", 128'({arvalid, rready, awvalid, wvalid, bready}), '0);
    chk("reset_status", 128'({ace_ready, ace_error, rack, wack}), '0);
    chk("reset_rd", 128'({rd_data, rd_shared, rd_pass_dirty}), '0);
    reset = 1'b1;
    @(negedge clk);

    // Plain ReadShared, zero-wait interconnect
    rsp_rdata = fill_a5; rsp_rresp = 4'b1000;
    @(negedge clk);
    req_addr = 32'h40; read_req = 1'b1; c = cyc;
    push_ar(32'h40, 4'b0001);
    push_done(c + 3, 1'b0, 1'b1, 1'b0, fill_a5, 1'b1, 1'b0);
    wait_ready(20);
    read_req = 1'b0;

    // WriteBack with AW immediate, W after 3 waits, B after 1 wait
    aw_wait = 0; w_wait = 3; b_wait = 1; rsp_bresp = 2'b00;
    @(negedge clk);
    req_addr = 32'h1000; wb_data = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    write_req = 1'b1; c = cyc;
    aw_q.push_back(32'h1000); w_q.push_back(wb_data);
    push_done(c + 7, 1'b0, 1'b0, 1'b1, fill_a5, 1'b1, 1'b0);
    wait_ready(30);
    write_req = 1'b0; w_wait = 0; b_wait = 0;

    // Write and read together: write first, one IDLE cycle, then the read
    rsp_rdata = fill_12; rsp_rresp = 4'b0100;
    @(negedge clk);
    req_addr = 32'h2000; wb_data = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
    write_req = 1'b1; read_req = 1'b1; c = cyc;
    aw_q.push_back(32'h2000); w_q.push_back(wb_data);
    push_ar(32'h2000, 4'b0001);
    push_done(c + 3, 1'b0, 1'b0, 1'b1, fill_a5, 1'b1, 1'b0);
    push_done(c + 7, 1'b0, 1'b1, 1'b0, fill_12, 1'b0, 1'b1);
    wait_ready(20);
    write_req = 1'b0;
    wait_ready(20);
    read_req = 1'b0;

    // CleanUnique from a one-cycle pulse; fill registers untouched
    rsp_rdata = {8{16'hDEAD}}; rsp_rresp = 4'b1100;
    @(negedge clk);
    req_addr = 32'h3000; invalid_req = 1'b1; c = cyc;
    push_ar(32'h3000, 4'b1011);
    push_done(c + 3, 1'b0, 1'b1, 1'b0, fill_12, 1'b0, 1'b1);
    @(negedge clk);
    invalid_req = 1'b0;
    wait_ready(20);

    // arready never comes: timeout 8 cycles after AR entry
    ar_wait = -1;
    @(negedge clk);
    req_addr = 32'h5000; read_req = 1'b1; c = cyc;
    push_done(c + 9, 1'b1, 1'b0, 1'b0, fill_12, 1'b0, 1'b1);
    wait_ready(30);
    read_req = 1'b0; ar_wait = 0;
    @(negedge clk);
    chk("ar_low_after_timeout", 128'(arvalid), '0);

    // WriteBack answered with SLVERR
    rsp_bresp = 2'b10;
    @(negedge clk);
    req_addr = 32'h4000; wb_data = {4{32'h0BAD_BEEF}};
    write_req = 1'b1; c = cyc;
    aw_q.push_back(32'h4000); w_q.push_back(wb_data);
    push_done(c + 3, 1'b1, 1'b0, 1'b1, fill_12, 1'b0, 1'b1);
    wait_ready(20);
    write_req = 1'b0; rsp_bresp = 2'b00;

    // Read answered with SLVERR: rack still issued, fill registers kept
    rsp_rdata = {4{32'hBEEF_0000}}; rsp_rresp = 4'b1010;
    @(negedge clk);
    req_addr = 32'h4400; read_req = 1'b1; c = cyc;
    push_ar(32'h4400, 4'b0001);
    push_done(c + 3, 1'b1, 1'b1, 1'b0, fill_12, 1'b0, 1'b1);
    wait_ready(20);
    read_req = 1'b0;

    // Asynchronous reset while waiting in R
    r_wait = -1;
    @(negedge clk);
    req_addr = 32'h6000; read_req = 1'b1;
    push_ar(32'h6000, 4'b0001);
    c = 0;
    while (!rready && c < 10) begin
      @(negedge clk);
      c++;
    end
    if (!rready) begin
      n_checks++; n_fail++;
      $display("FAIL reach_r: rready not seen within 10 cycles");
    end
    #1 reset = 1'b0;
    #1;
    chk("async_reset_valids", 128'({arvalid, rready, awvalid, wvalid, bready}), '0);
    chk("async_reset_status", 128'({ace_ready, ace_error, rack, wack}), '0);
    chk("async_reset_rd", 128'({rd_data, rd_shared, rd_pass_dirty}), '0);
    read_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; r_wait = 0;

    // Back to normal after reset release
    rsp_rdata = fill_55; rsp_rresp = 4'b0000;
    @(negedge clk);
    req_addr = 32'h7000; read_req = 1'b1; c = cyc;
    push_ar(32'h7000, 4'b0001);
    push_done(c + 3, 1'b0, 1'b1, 1'b0, fill_55, 1'b0, 1'b0);
    wait_ready(20);
    read_req = 1'b0;

    repeat (5) @(negedge clk);
    chk("done_q_drained", 128'(done_q.size()), '0);
    chk("ar_q_drained", 128'(ar_q.size()), '0);
    chk("aw_w_q_drained", 128'(aw_q.size() + w_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
